ring_sequence_checker: RTL and testbench
========================================

# ring_sequence_checker

Receive-side monitor for the 4-phase one-hot ring counter outputs q0..q3. It samples the four phase lines every clock, encodes them to a 2-bit phase index, and checks that each sample is strictly one-hot. It locks onto the S0→S1→S2→S3→S0 rotation and flags any broken step. It sits at the consumer end of the ring, feeding status and counters to the debug/CSR logic.

## Interface
- LOCK_CNT, default 4: consecutive correct steps required to assert locked (legal range 1..15).
- ERR_W, default 8: width of the saturating error counter.
- ROT_W, default 16: width of the wrapping rotation counter.

- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- q0, q1, q2, q3  in  1 each  ring phase lines; exactly one is expected high.
- idx  out  2  registered phase index of last sample (q0→0 … q3→3); holds previous value when the sample is not one-hot.
- onehot_ok  out  1  registered; 1 when the last sample had exactly one line high.
- locked  out  1  registered; 1 while in LOCK.
- seq_err  out  1  one-cycle pulse on loss of lock.
- err_count  out  ERR_W  count of seq_err pulses; saturates at all-ones.
- rot_count  out  ROT_W  completed rotations (3→0 steps) while locked; wraps modulo 2^ROT_W.

## Operation
- Sample decode is combinational: v = exactly one of q0..q3 high; n = encoded index. Zero-hot and multi-hot are invalid.
- A step is good when v=1 and n == (last_idx+1) mod 4.
- Internal registers: state, last_idx[1:0], good_cnt[3:0].
- FSM states are IDLE, HUNT, and LOCK. Reset enters IDLE.
- IDLE:
  - v=1 → last_idx=n, good_cnt=0, go to HUNT.
  - v=0 → stay in IDLE.
- HUNT:
  - Good step → last_idx=n, good_cnt+1. If good_cnt+1 == LOCK_CNT, go to LOCK.
  - v=1 but wrong step → last_idx=n, good_cnt=0, stay in HUNT. No seq_err.
  - v=0 → go to IDLE, good_cnt=0.
- LOCK:
  - Good step → last_idx=n. If last_idx==3 and n==0, rot_count+1.
  - Wrong step or v=0 → seq_err=1 for one cycle, err_count+1 (saturating), good_cnt=0.
    - Wrong step: go to HUNT with last_idx=n.
    - v=0: go to IDLE.
- The same sample that loses lock never counts as a rotation.
- Errors are only reported from LOCK. Garbage before first lock is silent.
- Holding the same valid value is a wrong step (a stuck ring is an error).
- Counters never reset except via reset. err_count holds at 2^ERR_W−1; rot_count wraps to 0 silently.

## Timing
- All outputs are registered and update on the rising clk edge that samples q0..q3.
  - Latency: 1 cycle from input to idx/onehot_ok/locked/seq_err/counters.
- q0..q3 are synchronous to clk (same-clock ring). No synchronizer.
- locked rises on the edge that accepts the LOCK_CNT-th good step after the anchor sample.
  - For a clean ring from reset, that is LOCK_CNT+1 edges after the first valid sample.
- seq_err is high for exactly one cycle per loss of lock. locked falls on that same edge.
- Reset values: idx=0, onehot_ok=0, locked=0, seq_err=0, err_count=0, rot_count=0; state=IDLE, last_idx=0, good_cnt=0.
- Reset asserted mid-operation clears everything asynchronously. After release, relocking requires a fresh anchor plus LOCK_CNT good steps.

## Structure
- Shared package ring_pkg holds:
  - the ring phase enum (S0..S3, logic [1:0]), shared with the ring generator;
  - the checker FSM enum (IDLE, HUNT, LOCK);
  - helper function next_phase(p) = p+1 mod 4.
- One combinational sub-module, onehot4_decode: inputs q0..q3; outputs v and n[1:0].
- The top holds the FSM, the registers, and both counters.

## Test plan
- Clean ring from reset, phases 0,1,2,3,0,1… with LOCK_CNT=4:
  - locked=1 after edge 5 following the first sample;
  - idx tracks the phases with 1-cycle lag;
  - after 3 full rotations past lock, rot_count=3 and err_count=0.
- Inject phase skip 1→3 while locked:
  - seq_err pulses once and locked=0 on that edge;
  - err_count=1 and state is HUNT;
  - relocks after 4 further good steps.
- Inject 4'b0000, then 4'b0101, while locked:
  - first edge: seq_err=1, onehot_ok=0, idx holds, state IDLE;
  - second (invalid) sample: no further seq_err;
  - err_count=1.
- Stuck ring: phase 2 held for 2 cycles while locked → seq_err, err_count+1, HUNT.
- Saturation with ERR_W=2: force 5 lock/unlock cycles → err_count=3. Separately, ROT_W=2 after 5 rotations → rot_count=1.
- Assert reset for one cycle mid-rotation while locked:
  - all outputs 0 immediately, without waiting for a clock edge;
  - no seq_err on release;
  - relock timing matches the first scenario.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the 4-phase one-hot ring and its sequence checker.
//   phase_t      : ring phase index S0..S3, shared with the ring generator
//   chk_state_t  : sequence checker FSM states
//   next_phase() : successor of a phase around the ring (wraps 3 -> 0)
package ring_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } chk_state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/onehot4_decode.sv
// Combinational one-hot decoder for the four ring phase lines.
//   q0..q3 : ring phase lines
//   v      : 1 when exactly one line is high
//   n      : index of the high line (0 when v=0)
module onehot4_decode
  import ring_pkg::*;
(
  input  logic       q0,
  input  logic       q1,
  input  logic       q2,
  input  logic       q3,
  output logic       v,
  output logic [1:0] n
);

  // Zero-hot and multi-hot patterns both fall to the invalid default.
  always_comb begin
    v = 1'b0;
    n = 2'd0;
    case ({q3, q2, q1, q0})
      4'b0001: begin v = 1'b1; n = S0; end
      4'b0010: begin v = 1'b1; n = S1; end
      4'b0100: begin v = 1'b1; n = S2; end
      4'b1000: begin v = 1'b1; n = S3; end
      default: begin v = 1'b0; n = 2'd0; end
    endcase
  end

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side monitor for the 4-phase one-hot ring. Locks onto the
// S0->S1->S2->S3->S0 rotation and reports broken steps once locked.
//   clk, reset     : clock and asynchronous active-high reset
//   q0..q3         : ring phase lines
//   idx            : phase index of the last valid sample
//   onehot_ok      : last sample was strictly one-hot
//   locked         : checker is in LOCK
//   seq_err        : one-cycle pulse on loss of lock
//   err_count      : saturating count of seq_err pulses
//   rot_count      : wrapping count of 3->0 steps while locked
module ring_sequence_checker
  import ring_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int ROT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q0,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  output logic [1:0]       idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic [ROT_W-1:0] rot_count
);

  localparam logic [3:0]       LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX_C  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE_C  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ROT_W-1:0] ROT_ONE_C  = {{(ROT_W-1){1'b0}}, 1'b1};

  logic             v_s;
  logic [1:0]       n_s;
  logic             good_step_s;
  logic             lock_hit_s;

  chk_state_t       state_r;
  logic [1:0]       last_idx_r;
  logic [3:0]       good_cnt_r;
  logic             onehot_ok_r;
  logic             locked_r;
  logic             seq_err_r;
  logic [ERR_W-1:0] err_count_r;
  logic [ROT_W-1:0] rot_count_r;

  onehot4_decode u_decode (
    .q0 (q0),
    .q1 (q1),
    .q2 (q2),
    .q3 (q3),
    .v  (v_s),
    .n  (n_s)
  );

  assign good_step_s = v_s && (n_s == next_phase(last_idx_r));
  assign lock_hit_s  = (good_cnt_r + 4'd1) == LOCK_CNT_C;

  // Checker FSM with its registered status outputs and both counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      last_idx_r  <= 2'd0;
      good_cnt_r  <= 4'd0;
      onehot_ok_r <= 1'b0;
      locked_r    <= 1'b0;
      seq_err_r   <= 1'b0;
      err_count_r <= '0;
      rot_count_r <= '0;
    end else begin
      onehot_ok_r <= v_s;
      seq_err_r   <= 1'b0;
      // Every valid sample becomes the new reference; invalid ones hold it.
      if (v_s) begin
        last_idx_r <= n_s;
      end
      case (state_r)
        IDLE: begin
          if (v_s) begin
            good_cnt_r <= 4'd0;
            state_r    <= HUNT;
          end
        end
        HUNT: begin
          if (good_step_s) begin
            good_cnt_r <= good_cnt_r + 4'd1;
            if (lock_hit_s) begin
              state_r  <= LOCK;
              locked_r <= 1'b1;
            end
          end else if (v_s) begin
            good_cnt_r <= 4'd0;
          end else begin
            good_cnt_r <= 4'd0;
            state_r    <= IDLE;
          end
        end
        LOCK: begin
          if (good_step_s) begin
            // A good step out of S3 necessarily lands on S0: one rotation.
            if (last_idx_r == S3) begin
              rot_count_r <= rot_count_r + ROT_ONE_C;
            end
          end else begin
            seq_err_r  <= 1'b1;
            locked_r   <= 1'b0;
            good_cnt_r <= 4'd0;
            if (err_count_r != ERR_MAX_C) begin
              err_count_r <= err_count_r + ERR_ONE_C;
            end
            state_r <= v_s ? HUNT : IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          locked_r   <= 1'b0;
          good_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign idx       = last_idx_r;
  assign onehot_ok = onehot_ok_r;
  assign locked    = locked_r;
  assign seq_err   = seq_err_r;
  assign err_count = err_count_r;
  assign rot_count = rot_count_r;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed testbench for ring_sequence_checker: default-parameter instance
// plus a LOCK_CNT=1, ERR_W=2, ROT_W=2 instance for counter saturation/wrap.
module tb_ring_sequence_checker;
  import ring_pkg::*;

  logic        clk = 1'b0;
  logic        rst1 = 1'b1;
  logic        rst2 = 1'b1;
  logic [3:0]  q = 4'b0000;

  logic [1:0]  idx1, idx2;
  logic        ok1, ok2, lk1, lk2, se1, se2;
  logic [7:0]  ec1;
  logic [15:0] rc1;
  logic [1:0]  ec2, rc2;

  int chk_cnt = 0;
  int err_cnt = 0;

  ring_sequence_checker dut (
    .clk(clk), .reset(rst1), .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
    .idx(idx1), .onehot_ok(ok1), .locked(lk1), .seq_err(se1),
    .err_count(ec1), .rot_count(rc1)
  );

  ring_sequence_checker #(.LOCK_CNT(1), .ERR_W(2), .ROT_W(2)) dut2 (
    .clk(clk), .reset(rst2), .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
    .idx(idx2), .onehot_ok(ok2), .locked(lk2), .seq_err(se2),
    .err_count(ec2), .rot_count(rc2)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ph(input int p);
    return 4'b0001 << p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample on the falling edge, return just after the rising edge.
  task automatic step(input logic [3:0] qv);
    @(negedge clk);
    q = qv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_idx", 32'(idx1), 32'd0);
    check("rst_ok", 32'(ok1), 32'd0);
    check("rst_locked", 32'(lk1), 32'd0);
    check("rst_seqerr", 32'(se1), 32'd0);
    check("rst_err", 32'(ec1), 32'd0);
    check("rst_rot", 32'(rc1), 32'd0);
    @(negedge clk);
    rst1 = 1'b0;

    // Clean ring: anchor on 0, lock after 4 good steps
    step(ph(0));
    check("s1_anchor_idx", 32'(idx1), 32'd0);
    check("s1_anchor_ok", 32'(ok1), 32'd1);
    check("s1_anchor_lk", 32'(lk1), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(ph(i));
      check("s1_hunt_idx", 32'(idx1), 32'(i));
      check("s1_hunt_lk", 32'(lk1), 32'd0);
    end
    step(ph(0));
    check("s1_lock_lk", 32'(lk1), 32'd1);
    check("s1_lock_rot", 32'(rc1), 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) begin
        step(ph(i % 4));
        check("s1_rot_idx", 32'(idx1), 32'(i % 4));
        check("s1_rot_se", 32'(se1), 32'd0);
      end
    end
    check("s1_rot_cnt", 32'(rc1), 32'd3);
    check("s1_err_cnt", 32'(ec1), 32'd0);

    // Phase skip 1 -> 3 while locked
    step(ph(1));
    step(ph(3));
    check("s2_skip_se", 32'(se1), 32'd1);
    check("s2_skip_lk", 32'(lk1), 32'd0);
    check("s2_skip_err", 32'(ec1), 32'd1);
    check("s2_skip_state", 32'(dut.state_r), 32'(HUNT));
    check("s2_skip_idx", 32'(idx1), 32'd3);
    for (int i = 0; i <= 2; i++) begin
      step(ph(i));
      check("s2_relock_lo", 32'(lk1), 32'd0);
      check("s2_pulse_once", 32'(se1), 32'd0);
    end
    step(ph(3));
    check("s2_relock_hi", 32'(lk1), 32'd1);
    check("s2_rot_hold", 32'(rc1), 32'd3);

    // Zero-hot then multi-hot while locked (last phase 3)
    step(4'b0000);
    check("s3_zero_se", 32'(se1), 32'd1);
    check("s3_zero_ok", 32'(ok1), 32'd0);
    check("s3_zero_idx", 32'(idx1), 32'd3);
    check("s3_zero_state", 32'(dut.state_r), 32'(IDLE));
    step(4'b0101);
    check("s3_multi_se", 32'(se1), 32'd0);
    check("s3_multi_ok", 32'(ok1), 32'd0);
    check("s3_multi_idx", 32'(idx1), 32'd3);
    check("s3_err", 32'(ec1), 32'd2);
    step(ph(0));
    for (int i = 1; i <= 4; i++) step(ph(i % 4));
    check("s3_relock", 32'(lk1), 32'd1);

    // Stuck ring: phase 2 held twice while locked
    step(ph(1));
    step(ph(2));
    check("s4_pre_se", 32'(se1), 32'd0);
    step(ph(2));
    check("s4_stuck_se", 32'(se1), 32'd1);
    check("s4_stuck_err", 32'(ec1), 32'd3);
    check("s4_stuck_state", 32'(dut.state_r), 32'(HUNT));
    for (int i = 3; i <= 6; i++) step(ph(i % 4));
    check("s4_relock", 32'(lk1), 32'd1);
    check("s4_rot", 32'(rc1), 32'd3);

    // Asynchronous reset mid-rotation while locked (last phase 2)
    step(ph(3));
    check("s6_pre_lk", 32'(lk1), 32'd1);
    #2;
    rst1 = 1'b1;
    q = ph(0);
    #1;
    check("s6_async_lk", 32'(lk1), 32'd0);
    check("s6_async_idx", 32'(idx1), 32'd0);
    check("s6_async_err", 32'(ec1), 32'd0);
    check("s6_async_rot", 32'(rc1), 32'd0);
    check("s6_async_ok", 32'(ok1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    check("s6_anchor_se", 32'(se1), 32'd0);
    check("s6_anchor_ok", 32'(ok1), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(ph(i));
      check("s6_hunt_lk", 32'(lk1), 32'd0);
      check("s6_hunt_se", 32'(se1), 32'd0);
    end
    step(ph(0));
    check("s6_relock", 32'(lk1), 32'd1);

    // Small-width instance: err_count saturation
    rst1 = 1'b1;
    q = 4'b0000;
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(ph(0));
      step(ph(1));
      check("s5_lock", 32'(lk2), 32'd1);
      step(4'b0000);
      check("s5_se", 32'(se2), 32'd1);
      check("s5_err", 32'(ec2), (c < 3) ? 32'(c + 1) : 32'd3);
    end

    // Small-width instance: rot_count wrap after 5 rotations
    @(negedge clk);
    rst2 = 1'b1;
    q = ph(0);
    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    step(ph(1));
    check("s5_rot_lock", 32'(lk2), 32'd1);
    step(ph(2));
    step(ph(3));
    step(ph(0));
    check("s5_rot1", 32'(rc2), 32'd1);
    for (int r = 0; r < 3; r++)
      for (int i = 1; i <= 4; i++) step(ph(i % 4));
    check("s5_rot4", 32'(rc2), 32'd0);
    for (int i = 1; i <= 4; i++) step(ph(i % 4));
    check("s5_rot5", 32'(rc2), 32'd1);
    check("s5_rot_err", 32'(ec2), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
